// File: rtl/dwc_pkg.sv
// dwc_pkg: shared definitions for the DWC checker AXI4-Lite register block.
// Register word offsets (AWADDR/ARADDR[3:2]), CTRL/STATUS bit indices,
// AXI response encoding, channel FSM state types and a byte-strobe merge helper.
package dwc_pkg;

    // Register word indices (byte offset >> 2)
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CNT     = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    // CTRL bit indices
    localparam int CTRL_EN       = 0;
    localparam int CTRL_CLR      = 1;
    localparam int CTRL_IRQ_MASK = 2;

    // STATUS bit indices
    localparam int STATUS_MISMATCH_STKY = 0;
    localparam int STATUS_LAST_MISMATCH = 1;
    localparam int STATUS_SKEW_STKY     = 2;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR_HELD,
        WR_DATA_HELD,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_e;

    // Merge new_val into old_val byte by byte where strb is set
    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/dwc_compare.sv
// dwc_compare: compares paired results from two redundant cores.
// Sets sticky/last mismatch and skew flags, keeps a saturating mismatch counter.
// Optional feature: DWC_IRQ_EN adds a one-cycle irq pulse per counted mismatch.
module dwc_compare
    import dwc_pkg::*;
#(
    parameter int C_CORE_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic [C_CORE_WIDTH-1:0] a_data,
    input  logic                    a_valid,
    input  logic [C_CORE_WIDTH-1:0] b_data,
    input  logic                    b_valid,
`ifdef DWC_IRQ_EN
    input  logic                    irq_mask,
    output logic                    irq,
`endif
    output logic                    mismatch_stky,
    output logic                    last_mismatch,
    output logic                    skew_stky,
    output logic [31:0]             cnt
);

    logic mismatch;
    assign mismatch = (a_data != b_data);

    // Compare event processing; clear takes priority over a same-cycle compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_stky <= 1'b0;
            last_mismatch <= 1'b0;
            skew_stky     <= 1'b0;
            cnt           <= '0;
`ifdef DWC_IRQ_EN
            irq           <= 1'b0;
`endif
        end else begin
`ifdef DWC_IRQ_EN
            irq <= 1'b0;
`endif
            if (clr) begin
                mismatch_stky <= 1'b0;
                last_mismatch <= 1'b0;
                skew_stky     <= 1'b0;
                cnt           <= '0;
            end else if (en) begin
                if (a_valid && b_valid) begin
                    last_mismatch <= mismatch;
                    if (mismatch) begin
                        mismatch_stky <= 1'b1;
                        if (cnt != '1) cnt <= cnt + 32'd1;
`ifdef DWC_IRQ_EN
                        irq <= !irq_mask;
`endif
                    end
                end else if (a_valid ^ b_valid) begin
                    skew_stky <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dwc_axil_regs.sv
// dwc_axil_regs: AXI4-Lite responder exposing the DWC checker registers
// (CTRL, STATUS, MISMATCH_CNT, SCRATCH). One outstanding write, one outstanding read.
// Optional feature: DWC_IRQ_EN adds the dwc_irq port and the RW CTRL[2] IRQ_MASK bit.
module dwc_axil_regs
    import dwc_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_CORE_WIDTH       = 32
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [C_CORE_WIDTH-1:0]         core_a_data,
    input  logic                            core_a_valid,
    input  logic [C_CORE_WIDTH-1:0]         core_b_data,
    input  logic                            core_b_valid,
`ifdef DWC_IRQ_EN
    output logic                            dwc_irq,
`endif
    output logic                            dwc_error
);

    wr_state_e   wr_state, wr_next;
    rd_state_e   rd_state, rd_next;

    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [1:0]  aw_idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        reg_we;
    logic [1:0]  we_idx;
    logic [31:0] we_data;
    logic [3:0]  we_strb;

    logic        ctrl_en;
    logic        ctrl_clr;
    logic        ctrl_irq_mask_rd;
    logic [31:0] scratch;

    logic        st_mismatch_stky, st_last_mismatch, st_skew_stky;
    logic [31:0] mismatch_cnt;

    logic [31:0] rd_mux;
    logic [31:0] rdata_q;

    logic        unused_axi;
    assign unused_axi = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign b_hs  = S_AXI_BVALID  && S_AXI_BREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
    assign r_hs  = S_AXI_RVALID  && S_AXI_RREADY;

    assign S_AXI_BVALID = (wr_state == WR_RESP);
    assign S_AXI_BRESP  = RESP_OKAY;
    assign S_AXI_RVALID = (rd_state == RD_RESP);
    assign S_AXI_RRESP  = RESP_OKAY;
    assign S_AXI_RDATA  = rdata_q;

    // Write FSM next state; the register write strobe fires on the handshake that
    // completes the AW/W pair, taking each half from the live bus or its latch
    always_comb begin
        wr_next = wr_state;
        reg_we  = 1'b0;
        we_idx  = aw_idx_q;
        we_data = wdata_q;
        we_strb = wstrb_q;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_next = WR_RESP;
                    reg_we  = 1'b1;
                    we_idx  = S_AXI_AWADDR[3:2];
                    we_data = S_AXI_WDATA;
                    we_strb = S_AXI_WSTRB;
                end else if (aw_hs) begin
                    wr_next = WR_ADDR_HELD;
                end else if (w_hs) begin
                    wr_next = WR_DATA_HELD;
                end
            end
            WR_ADDR_HELD: begin
                if (w_hs) begin
                    wr_next = WR_RESP;
                    reg_we  = 1'b1;
                    we_data = S_AXI_WDATA;
                    we_strb = S_AXI_WSTRB;
                end
            end
            WR_DATA_HELD: begin
                if (aw_hs) begin
                    wr_next = WR_RESP;
                    reg_we  = 1'b1;
                    we_idx  = S_AXI_AWADDR[3:2];
                end
            end
            WR_RESP: begin
                if (b_hs) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    // Write FSM state, registered READYs (low in reset) and AW/W latches
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state      <= WR_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            aw_idx_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            wr_state      <= wr_next;
            S_AXI_AWREADY <= (wr_next == WR_IDLE) || (wr_next == WR_DATA_HELD);
            S_AXI_WREADY  <= (wr_next == WR_IDLE) || (wr_next == WR_ADDR_HELD);
            if (aw_hs) aw_idx_q <= S_AXI_AWADDR[3:2];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
        end
    end

    // RW register file; CLR is a one-cycle pulse regardless of what was written before
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_en  <= 1'b0;
            ctrl_clr <= 1'b0;
            scratch  <= '0;
        end else begin
            ctrl_clr <= 1'b0;
            if (reg_we) begin
                case (we_idx)
                    REG_CTRL: begin
                        if (we_strb[0]) begin
                            ctrl_en  <= we_data[CTRL_EN];
                            ctrl_clr <= we_data[CTRL_CLR];
                        end
                    end
                    REG_SCRATCH: scratch <= apply_strb(scratch, we_data, we_strb);
                    default: ;
                endcase
            end
        end
    end

`ifdef DWC_IRQ_EN
    logic ctrl_irq_mask;

    // IRQ mask bit of CTRL
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_irq_mask <= 1'b0;
        end else if (reg_we && (we_idx == REG_CTRL) && we_strb[0]) begin
            ctrl_irq_mask <= we_data[CTRL_IRQ_MASK];
        end
    end

    assign ctrl_irq_mask_rd = ctrl_irq_mask;
`else
    assign ctrl_irq_mask_rd = 1'b0;
`endif

    dwc_compare #(
        .C_CORE_WIDTH (C_CORE_WIDTH)
    ) u_cmp (
        .clk           (S_AXI_ACLK),
        .rst_n         (S_AXI_ARESETN),
        .en            (ctrl_en),
        .clr           (ctrl_clr),
        .a_data        (core_a_data),
        .a_valid       (core_a_valid),
        .b_data        (core_b_data),
        .b_valid       (core_b_valid),
`ifdef DWC_IRQ_EN
        .irq_mask      (ctrl_irq_mask),
        .irq           (dwc_irq),
`endif
        .mismatch_stky (st_mismatch_stky),
        .last_mismatch (st_last_mismatch),
        .skew_stky     (st_skew_stky),
        .cnt           (mismatch_cnt)
    );

    assign dwc_error = st_mismatch_stky;

    // Read data select; upper address bits alias onto the four registers
    always_comb begin
        rd_mux = '0;
        case (S_AXI_ARADDR[3:2])
            REG_CTRL: begin
                rd_mux[CTRL_EN]       = ctrl_en;
                rd_mux[CTRL_IRQ_MASK] = ctrl_irq_mask_rd;
            end
            REG_STATUS: begin
                rd_mux[STATUS_MISMATCH_STKY] = st_mismatch_stky;
                rd_mux[STATUS_LAST_MISMATCH] = st_last_mismatch;
                rd_mux[STATUS_SKEW_STKY]     = st_skew_stky;
            end
            REG_CNT:     rd_mux = mismatch_cnt;
            REG_SCRATCH: rd_mux = scratch;
            default:     rd_mux = '0;
        endcase
    end

    // Read FSM next state
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_next = RD_RESP;
            RD_RESP: if (r_hs)  rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    // Read FSM state, ARREADY and RDATA capture (pre-update register values)
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state      <= RD_IDLE;
            S_AXI_ARREADY <= 1'b0;
            rdata_q       <= '0;
        end else begin
            rd_state      <= rd_next;
            S_AXI_ARREADY <= (rd_next == RD_IDLE);
            if (ar_hs) rdata_q <= rd_mux;
        end
    end

endmodule

// File: tb/tb_dwc_axil_regs.sv
// tb_dwc_axil_regs: directed bench for dwc_axil_regs with a response scoreboard.
// Stimulus pushes expected R data / B resp into queues; a negedge monitor pops
// and compares on each R and B handshake.
module tb_dwc_axil_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] core_a_data;
    logic        core_a_valid;
    logic [31:0] core_b_data;
    logic        core_b_valid;
    logic        dwc_error;
`ifdef DWC_IRQ_EN
    logic        dwc_irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rexp_q[$];
    logic [3:0]  raddr_q[$];
    logic [1:0]  bexp_q[$];

    always #5 clk = ~clk;

    dwc_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .C_CORE_WIDTH       (32)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .core_a_data   (core_a_data),
        .core_a_valid  (core_a_valid),
        .core_b_data   (core_b_data),
        .core_b_valid  (core_b_valid),
`ifdef DWC_IRQ_EN
        .dwc_irq       (dwc_irq),
`endif
        .dwc_error     (dwc_error)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out, expected handshake", name);
    endtask

    // Scoreboard monitor: compare each R and B handshake against the queues
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            if (rexp_q.size() == 0) begin
                check("unexpected R beat", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                logic [3:0]  a;
                e = rexp_q.pop_front();
                a = raddr_q.pop_front();
                check($sformatf("rdata @0x%0h", a), rdata, e);
                check($sformatf("rresp @0x%0h", a), {30'd0, rresp}, 32'd0);
            end
        end
        if (rst_n && bvalid && bready) begin
            if (bexp_q.size() == 0) begin
                check("unexpected B beat", 32'd1, 32'd0);
            end else begin
                logic [1:0] eb;
                eb = bexp_q.pop_front();
                check("bresp", {30'd0, bresp}, {30'd0, eb});
            end
        end
    end

    // Full write with per-channel start delays (in cycles from task entry)
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int unsigned aw_dly, input int unsigned w_dly, input int unsigned b_dly);
        logic hs_aw, hs_w, hs_b;
        logic b_done;
        b_done = 1'b0;
        bexp_q.push_back(2'b00);
        bready = 1'b0;
        for (int unsigned k = 0; k < 64 && !b_done; k++) begin
            if (k == aw_dly) begin awaddr = addr; awvalid = 1'b1; end
            if (k == w_dly)  begin wdata = data; wstrb = strb; wvalid = 1'b1; end
            if (k == b_dly)  bready = 1'b1;
            @(negedge clk);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            hs_b  = bvalid && bready;
            @(posedge clk);
            #1;
            if (hs_aw) awvalid = 1'b0;
            if (hs_w)  wvalid  = 1'b0;
            if (hs_b)  b_done  = 1'b1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        if (!b_done) fail_now($sformatf("write B @0x%0h", addr));
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        axi_write(addr, data, 4'hF, 0, 0, 0);
    endtask

    task automatic rd(input logic [3:0] addr, input logic [31:0] exp);
        logic hs_ar, hs_r, r_done;
        r_done = 1'b0;
        rexp_q.push_back(exp);
        raddr_q.push_back(addr);
        araddr  = addr;
        arvalid = 1'b1;
        for (int unsigned k = 0; k < 64 && !r_done; k++) begin
            @(negedge clk);
            hs_ar = arvalid && arready;
            hs_r  = rvalid && rready;
            @(posedge clk);
            #1;
            if (hs_ar) arvalid = 1'b0;
            if (hs_r)  r_done  = 1'b1;
        end
        arvalid = 1'b0;
        if (!r_done) fail_now($sformatf("read R @0x%0h", addr));
    endtask

    task automatic core_pair(input logic [31:0] a, input logic [31:0] b, input logic va, input logic vb);
        core_a_data  = a;
        core_b_data  = b;
        core_a_valid = va;
        core_b_valid = vb;
        @(posedge clk);
        #1;
        core_a_valid = 1'b0;
        core_b_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hs_ar;
        rst_n = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        core_a_data = '0; core_b_data = '0; core_a_valid = 1'b0; core_b_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset readies", {29'd0, awready, wready, arready}, 32'd0);
        check("reset valids", {30'd0, bvalid, rvalid}, 32'd0);
        check("reset resp", {28'd0, bresp, rresp}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset dwc_error", {31'd0, dwc_error}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Regmap: RO writes ignored, CLR self-clears
        wr(4'h0, 32'd1);
        wr(4'h4, 32'd2);
        wr(4'h8, 32'd3);
        wr(4'hC, 32'd4);
        rd(4'h0, 32'd1);
        rd(4'h4, 32'd0);
        rd(4'h8, 32'd0);
        rd(4'hC, 32'd4);
        rd(4'hD, 32'd4);
        wr(4'h0, 32'd7);
`ifdef DWC_IRQ_EN
        rd(4'h0, 32'd5);
`else
        rd(4'h0, 32'd1);
`endif
        wr(4'h0, 32'd1);

        // Compare pairs with EN=1
        core_pair(32'd5, 32'd5, 1'b1, 1'b1);
        core_pair(32'd5, 32'd6, 1'b1, 1'b1);
        core_pair(32'd7, 32'd8, 1'b1, 1'b1);
        rd(4'h8, 32'd2);
        rd(4'h4, 32'h3);
        check("dwc_error after mismatches", {31'd0, dwc_error}, 32'd1);

        // CLR, then skew
        wr(4'h0, 32'd3);
        rd(4'h4, 32'h0);
        rd(4'h8, 32'd0);
        check("dwc_error after clr", {31'd0, dwc_error}, 32'd0);
        core_pair(32'd9, 32'd0, 1'b1, 1'b0);
        rd(4'h4, 32'h4);
        rd(4'h8, 32'd0);

        // CLR write coincident with a mismatch pair: clear wins
        bexp_q.push_back(2'b00);
        awaddr = 4'h0; awvalid = 1'b1;
        wdata = 32'd3; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b1;
        @(negedge clk);
        check("clr aw/w ready", {30'd0, awready, wready}, 32'd3);
        @(posedge clk);
        #1;
        awvalid = 1'b0; wvalid = 1'b0;
        core_a_data = 32'd1; core_b_data = 32'd2;
        core_a_valid = 1'b1; core_b_valid = 1'b1;
        @(posedge clk);
        #1;
        core_a_valid = 1'b0; core_b_valid = 1'b0;
        @(posedge clk);
        #1;
        rd(4'h8, 32'd0);
        rd(4'h4, 32'h0);

        // EN=0 freezes state
        wr(4'h0, 32'd0);
        core_pair(32'd1, 32'd2, 1'b1, 1'b1);
        core_pair(32'd1, 32'd0, 1'b1, 1'b0);
        rd(4'h8, 32'd0);
        rd(4'h4, 32'h0);

        // W 3 cycles ahead of AW, BREADY held low, byte-lane strobe
        wr(4'hC, 32'd0);
        axi_write(4'hC, 32'h0000_AABB, 4'b0010, 3, 0, 9);
        repeat (2) begin
            @(negedge clk);
            check("no extra bvalid", {31'd0, bvalid}, 32'd0);
        end
        @(posedge clk);
        #1;
        rd(4'hC, 32'h0000_AA00);

        // Counter saturation
        wr(4'h0, 32'd1);
        force dut.u_cmp.cnt = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.u_cmp.cnt;
        rd(4'h8, 32'hFFFF_FFFF);
        core_pair(32'd3, 32'd4, 1'b1, 1'b1);
        rd(4'h8, 32'hFFFF_FFFF);
        rd(4'h4, 32'h3);
        core_pair(32'd3, 32'd3, 1'b1, 1'b1);
        rd(4'h4, 32'h1);
        rd(4'h8, 32'hFFFF_FFFF);

        // Reset while a read response is pending
        rready  = 1'b0;
        araddr  = 4'hC;
        arvalid = 1'b1;
        hs_ar   = 1'b0;
        for (int unsigned k = 0; k < 16 && !hs_ar; k++) begin
            @(negedge clk);
            hs_ar = arready;
            @(posedge clk);
            #1;
        end
        arvalid = 1'b0;
        check("rvalid pending before reset", {31'd0, rvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rvalid in reset", {31'd0, rvalid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rvalid after reset release", {31'd0, rvalid}, 32'd0);
        end
        @(posedge clk);
        #1;
        rready = 1'b1;
        rd(4'hC, 32'd0);
        rd(4'h8, 32'd0);
        rd(4'h0, 32'd0);

        repeat (2) @(posedge clk);
        check("R queue drained", rexp_q.size(), 32'd0);
        check("B queue drained", bexp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
